exception_status_unit: RTL and testbench

EXCEPTION_STATUS_UNIT -- requirements
Module: exception_status_unit

---
 rtl/exception_status_unit_pkg.sv | 13 +
 rtl/exc_code_fifo.sv | 40 ++++
 rtl/exception_status_unit.sv | 71 +++++++
 tb/tb_exception_status_unit.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/exception_status_unit_pkg.sv
// exception_status_unit_pkg: shared register index and exception code constants
package exception_status_unit_pkg;
   localparam logic [4:0] RSTATUS_IDX = 5'd30;
   localparam int EXC_CODE_W = 3;
   typedef enum logic [EXC_CODE_W-1:0] {
      EXC_NONE = 3'd0,
      EXC_ADD  = 3'd1,
      EXC_ADDI = 3'd2,
      EXC_SUB  = 3'd3,
      EXC_MUL  = 3'd4,
      EXC_DIV  = 3'd5
   } exc_code_e;
endpackage

// File: rtl/exc_code_fifo.sv
// exc_code_fifo: first-word fall-through queue of pending exception codes
module exc_code_fifo
   import exception_status_unit_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int WIDTH = EXC_CODE_W
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] data_i,
   output logic             valid_o,
   output logic             full_o,
   output logic [WIDTH-1:0] data_o
);
   localparam int AW = $clog2(DEPTH);
   logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             do_push, do_pop;
   assign valid_o = wr_q != rd_q;
   assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign do_pop  = valid_o & pop_i;
   // a pop on the same edge frees the slot, so a full queue still accepts
   assign do_push = push_i & (~full_o | do_pop);
   assign data_o  = valid_o ? mem_q[rd_q[AW-1:0]] : '0;
   assign wr_d    = wr_q + {{AW{1'b0}}, do_push};
   assign rd_d    = rd_q + {{AW{1'b0}}, do_pop};
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_q <= '0;
         rd_q <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         wr_q <= wr_d;
         rd_q <= rd_d;
         if (do_push) mem_q[wr_q[AW-1:0]] <= data_i;
      end
   end
endmodule

// File: rtl/exception_status_unit.sv
// exception_status_unit: writeback port with rstatus override on overflow,
// exception code queue, saturating exception counter and sticky drop flag
module exception_status_unit
   import exception_status_unit_pkg::*;
#(
   parameter int QDEPTH = 2,
   parameter int CNTW   = 8
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  wb_valid_i,
   input  logic                  wb_overflow_i,
   input  logic [4:0]            wb_rd_i,
   input  logic                  wb_we_i,
   input  logic [31:0]           wb_result_i,
   input  logic [31:0]           exception_data_i,
   output logic                  rf_we_o,
   output logic [4:0]            rf_rd_o,
   output logic [31:0]           rf_data_o,
   output logic                  exc_valid_o,
   output logic [EXC_CODE_W-1:0] exc_code_o,
   input  logic                  exc_ready_i,
   output logic [CNTW-1:0]       exc_count_o,
   output logic                  exc_lost_o
);
   logic            exc_evt, q_full, drop;
   logic            rf_we_q, rf_we_d, lost_q, lost_d;
   logic [4:0]      rf_rd_q, rf_rd_d;
   logic [31:0]     rf_data_q, rf_data_d;
   logic [CNTW-1:0] cnt_q, cnt_d;
   assign exc_evt = wb_valid_i & wb_overflow_i & (exception_data_i != '0);
   always_comb begin
      rf_we_d   = exc_evt | (wb_valid_i & wb_we_i & (wb_rd_i != '0));
      rf_rd_d   = exc_evt ? RSTATUS_IDX : wb_rd_i;
      rf_data_d = exc_evt ? exception_data_i : wb_result_i;
      cnt_d     = (exc_evt && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
      lost_d    = lost_q | drop;
   end
   // dropped only when full and the head is not leaving on this edge
   assign drop = exc_evt & q_full & ~(exc_valid_o & exc_ready_i);
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rf_we_q   <= 1'b0;
         rf_rd_q   <= '0;
         rf_data_q <= '0;
         cnt_q     <= '0;
         lost_q    <= 1'b0;
      end else begin
         rf_we_q   <= rf_we_d;
         rf_rd_q   <= rf_rd_d;
         rf_data_q <= rf_data_d;
         cnt_q     <= cnt_d;
         lost_q    <= lost_d;
      end
   end
   exc_code_fifo #(.DEPTH(QDEPTH), .WIDTH(EXC_CODE_W)) u_fifo (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .push_i (exc_evt),
      .pop_i  (exc_ready_i),
      .data_i (exception_data_i[EXC_CODE_W-1:0]),
      .valid_o(exc_valid_o),
      .full_o (q_full),
      .data_o (exc_code_o)
   );
   assign rf_we_o     = rf_we_q;
   assign rf_rd_o     = rf_rd_q;
   assign rf_data_o   = rf_data_q;
   assign exc_count_o = cnt_q;
   assign exc_lost_o  = lost_q;
endmodule

// File: tb/tb_exception_status_unit.sv
// tb_exception_status_unit: directed vectors with hand-computed expectations
module tb_exception_status_unit;
   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        wb_valid_i = 1'b0, wb_overflow_i = 1'b0, wb_we_i = 1'b0, exc_ready_i = 1'b0;
   logic [4:0]  wb_rd_i = '0;
   logic [31:0] wb_result_i = '0, exception_data_i = '0;
   logic        rf_we_o, exc_valid_o, exc_lost_o;
   logic [4:0]  rf_rd_o;
   logic [31:0] rf_data_o;
   logic [2:0]  exc_code_o;
   logic [7:0]  exc_count_o;
   int          vectors = 0, miscompares = 0;

   exception_status_unit #(.QDEPTH(2), .CNTW(8)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .wb_valid_i(wb_valid_i), .wb_overflow_i(wb_overflow_i), .wb_rd_i(wb_rd_i),
      .wb_we_i(wb_we_i), .wb_result_i(wb_result_i), .exception_data_i(exception_data_i),
      .rf_we_o(rf_we_o), .rf_rd_o(rf_rd_o), .rf_data_o(rf_data_o),
      .exc_valid_o(exc_valid_o), .exc_code_o(exc_code_o), .exc_ready_i(exc_ready_i),
      .exc_count_o(exc_count_o), .exc_lost_o(exc_lost_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic ov, input logic [4:0] rd, input logic we,
                        input logic [31:0] res, input logic [31:0] ed, input logic rdy);
      wb_valid_i = v; wb_overflow_i = ov; wb_rd_i = rd; wb_we_i = we;
      wb_result_i = res; exception_data_i = ed; exc_ready_i = rdy;
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic do_reset();
      drive(0, 0, 0, 0, 0, 0, 0);
      rst_ni = 1'b0;
      @(negedge clk_i);
      rst_ni = 1'b1;
   endtask

   initial begin
      #2;
      chk("rst rf_we", rf_we_o, 0);
      chk("rst rf_rd", rf_rd_o, 0);
      chk("rst rf_data", rf_data_o, 0);
      chk("rst exc_valid", exc_valid_o, 0);
      chk("rst exc_code", exc_code_o, 0);
      chk("rst exc_count", exc_count_o, 0);
      chk("rst exc_lost", exc_lost_o, 0);
      // release with an exception already driven: nothing changes before the first edge
      @(negedge clk_i);
      drive(1, 1, 5, 1, 32'h1234, 1, 0);
      rst_ni = 1'b1;
      #1;
      chk("pre-edge rf_we", rf_we_o, 0);
      step();
      chk("add rf_we", rf_we_o, 1);
      chk("add rf_rd", rf_rd_o, 30);
      chk("add rf_data", rf_data_o, 1);
      chk("add exc_valid", exc_valid_o, 1);
      chk("add exc_code", exc_code_o, 1);
      chk("add exc_count", exc_count_o, 1);
      drive(0, 0, 0, 1, 0, 0, 1);
      step();
      chk("pop exc_valid", exc_valid_o, 0);
      chk("idle rf_we", rf_we_o, 0);
      step();
      chk("empty ready exc_valid", exc_valid_o, 0);
      chk("empty ready exc_lost", exc_lost_o, 0);
      drive(1, 1, 9, 1, 32'h55, 0, 0);
      step();
      chk("ovf0 rf_we", rf_we_o, 1);
      chk("ovf0 rf_rd", rf_rd_o, 9);
      chk("ovf0 rf_data", rf_data_o, 32'h55);
      chk("ovf0 exc_valid", exc_valid_o, 0);
      chk("ovf0 exc_count", exc_count_o, 1);
      drive(1, 0, 0, 1, 32'h77, 0, 0);
      step();
      chk("rd0 rf_we", rf_we_o, 0);
      drive(1, 0, 7, 1, 32'hDEADBEEF, 0, 0);
      step();
      chk("rd7 rf_we", rf_we_o, 1);
      chk("rd7 rf_rd", rf_rd_o, 7);
      chk("rd7 rf_data", rf_data_o, 32'hDEADBEEF);
      drive(0, 0, 7, 1, 32'h1, 0, 0);
      step();
      chk("bubble rf_we", rf_we_o, 0);
      drive(1, 0, 3, 0, 32'h1, 5, 0);
      step();
      chk("noovf exc_valid", exc_valid_o, 0);
      chk("noovf rf_we", rf_we_o, 0);

      do_reset();
      drive(1, 1, 1, 1, 0, 4, 0); step();
      drive(1, 1, 1, 1, 0, 5, 0); step();
      chk("fill2 exc_lost", exc_lost_o, 0);
      drive(1, 1, 1, 1, 0, 3, 0); step();
      chk("fill exc_code", exc_code_o, 4);
      chk("fill exc_lost", exc_lost_o, 1);
      chk("fill exc_count", exc_count_o, 3);
      drive(0, 0, 0, 0, 0, 0, 1); step();
      chk("fill pop1 code", exc_code_o, 5);
      chk("fill pop1 valid", exc_valid_o, 1);
      step();
      chk("fill pop2 valid", exc_valid_o, 0);
      chk("fill lost sticky", exc_lost_o, 1);

      do_reset();
      drive(1, 1, 1, 1, 0, 4, 0); step();
      drive(1, 1, 1, 1, 0, 5, 0); step();
      drive(1, 1, 1, 1, 0, 2, 1); step();
      chk("pushpop code", exc_code_o, 5);
      chk("pushpop valid", exc_valid_o, 1);
      chk("pushpop lost", exc_lost_o, 0);
      drive(0, 0, 0, 0, 0, 0, 1); step();
      chk("pushpop next code", exc_code_o, 2);
      step();
      chk("pushpop drained", exc_valid_o, 0);
      chk("pushpop count", exc_count_o, 3);

      do_reset();
      drive(1, 1, 1, 1, 0, 3, 1);
      for (int i = 1; i <= 300; i++) begin
         step();
         if (i == 254) chk("sat 254", exc_count_o, 254);
         if (i == 255) chk("sat 255", exc_count_o, 255);
         if (i == 256) chk("sat 256", exc_count_o, 255);
      end
      chk("sat hold", exc_count_o, 255);
      chk("sat lost", exc_lost_o, 0);

      do_reset();
      drive(1, 1, 1, 1, 0, 1, 0); step();
      drive(1, 1, 1, 1, 0, 2, 0); step();
      chk("burst count", exc_count_o, 2);
      chk("burst valid", exc_valid_o, 1);
      #2;
      rst_ni = 1'b0;
      #1;
      chk("async exc_valid", exc_valid_o, 0);
      chk("async exc_count", exc_count_o, 0);
      chk("async rf_we", rf_we_o, 0);
      chk("async exc_code", exc_code_o, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
